fsmc_bus_master: RTL and testbench

Synchronous FSMC-style initiator. It generates asynchronous-SRAM mode-1 bus cycles (NE/NOE/NWE, address, bidirectional data) from a simple request/done handshake on the internal clock. It is the counterpart of our clocked FSMC bus slave. It is used for on-chip loopback testing of the slave and for driving external SRAM-like peripherals from the FPGA. Strobe timing is fixed by parameters, in clk cycles.

---
 rtl/fsmc_bus_master.sv | 128 ++++++++++++
 tb/tb_fsmc_bus_master.sv | 135 +++++++++++++
 2 files changed

// File: rtl/fsmc_bus_master.sv
// fsmc_bus_master: FSMC mode-1 async-SRAM bus initiator with fixed, parameterised strobe timing
module fsmc_bus_master #(
  parameter int ADRW   = 2,
  parameter int DATW   = 3,
  parameter int ADDSET = 2,
  parameter int DATAST = 8,
  parameter int HOLD   = 2,
  parameter int GAP    = 2,
  parameter int CW     = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            req,
  input  logic            we,
  input  logic [ADRW-1:0] adr,
  input  logic [DATW-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [DATW-1:0] rdata,
  output logic            bNE,
  output logic            bNOE,
  output logic            bNWE,
  output logic [ADRW-1:0] bA,
  output logic [DATW-1:0] bD_out,
  output logic            bD_oe,
  input  logic [DATW-1:0] bD_in
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_HOLD, S_GAP} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic            bne_q, bne_d, bnoe_q, bnoe_d, bnwe_q, bnwe_d, bdoe_q, bdoe_d;
  logic [ADRW-1:0] ba_q, ba_d;
  logic [DATW-1:0] bdo_q, bdo_d, rdata_q, rdata_d;
  logic            last;
  assign last   = cnt_q == '0;
  assign busy   = busy_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign bNE    = bne_q;
  assign bNOE   = bnoe_q;
  assign bNWE   = bnwe_q;
  assign bA     = ba_q;
  assign bD_out = bdo_q;
  assign bD_oe  = bdoe_q;
  // phase sequencing; the end of GAP doubles as an IDLE edge so held req gives exactly GAP idle cycles
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? cnt_q : cnt_q - CW'(1);
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bne_d   = bne_q;
    bnoe_d  = bnoe_q;
    bnwe_d  = bnwe_q;
    bdoe_d  = bdoe_q;
    ba_d    = ba_q;
    bdo_d   = bdo_q;
    rdata_d = rdata_q;
    case (state_q)
      S_ADDR: if (last) begin
        state_d = S_DATA;
        cnt_d   = CW'(DATAST - 1);
        bnwe_d  = !we_q;
        bnoe_d  = we_q;
      end
      S_DATA: if (last) begin
        state_d = S_HOLD;
        cnt_d   = CW'(HOLD - 1);
        bnwe_d  = 1'b1;
        bnoe_d  = 1'b1;
        rdata_d = we_q ? rdata_q : bD_in;
      end
      S_HOLD: if (last) begin
        state_d = S_GAP;
        cnt_d   = CW'(GAP - 1);
        bne_d   = 1'b1;
        bdoe_d  = 1'b0;
        done_d  = 1'b1;
      end
      S_GAP: if (last) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: ;
    endcase
    if (req && (state_q == S_IDLE || (state_q == S_GAP && last))) begin
      state_d = S_ADDR;
      cnt_d   = CW'(ADDSET - 1);
      we_d    = we;
      busy_d  = 1'b1;
      bne_d   = 1'b0;
      ba_d    = adr;
      bdo_d   = we ? wdata : bdo_q;
      bdoe_d  = we;
    end
  end
  // all bus pins and status come straight from flops; reset drops any transaction at once
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bne_q   <= 1'b1;
      bnoe_q  <= 1'b1;
      bnwe_q  <= 1'b1;
      bdoe_q  <= 1'b0;
      ba_q    <= '0;
      bdo_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bne_q   <= bne_d;
      bnoe_q  <= bnoe_d;
      bnwe_q  <= bnwe_d;
      bdoe_q  <= bdoe_d;
      ba_q    <= ba_d;
      bdo_q   <= bdo_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_fsmc_bus_master.sv
// tb_fsmc_bus_master: directed checks of bus timing, loopback data, rejection, back-to-back and reset
module tb_fsmc_bus_master;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nrst, req, we, busy, done, bNE, bNOE, bNWE, bD_oe;
  logic [1:0] adr, bA;
  logic [2:0] wdata, rdata, bD_out, bD_in;
  logic req2, we2, busy2, done2, bNE2, bNOE2, bNWE2, bD_oe2;
  logic [1:0] adr2, bA2;
  logic [2:0] wdata2, rdata2, bD_out2, bD_in2;
  logic [2:0] mem1 [4];
  logic [2:0] mem2 [4];
  int n_tests = 0;
  int n_fail = 0;
  fsmc_bus_master dut (
    .clk(clk), .nrst(nrst), .req(req), .we(we), .adr(adr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .bNE(bNE), .bNOE(bNOE), .bNWE(bNWE),
    .bA(bA), .bD_out(bD_out), .bD_oe(bD_oe), .bD_in(bD_in)
  );
  fsmc_bus_master #(.ADDSET(1), .DATAST(1), .HOLD(1), .GAP(1)) dut2 (
    .clk(clk), .nrst(nrst), .req(req2), .we(we2), .adr(adr2), .wdata(wdata2),
    .busy(busy2), .done(done2), .rdata(rdata2), .bNE(bNE2), .bNOE(bNOE2), .bNWE(bNWE2),
    .bA(bA2), .bD_out(bD_out2), .bD_oe(bD_oe2), .bD_in(bD_in2)
  );
  // SRAM-like targets: latch on NWE rising with NE low, drive data while NE and NOE are low
  always @(posedge bNWE) if (!bNE) mem1[bA] <= bD_out;
  always @(posedge bNWE2) if (!bNE2) mem2[bA2] <= bD_out2;
  assign bD_in  = (!bNE && !bNOE) ? mem1[bA] : 3'b000;
  assign bD_in2 = (!bNE2 && !bNOE2) ? mem2[bA2] : 3'b000;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // {bNE,bNOE,bNWE,bD_oe,done,busy} k cycles after the req-sampling edge
  function automatic logic [5:0] bus_exp(int k, logic wr, int a, int d, int h, int g);
    int n;
    logic sl;
    n  = a + d + h;
    sl = k >= a && k < a + d;
    return {!(k < n), !(!wr && sl), !(wr && sl), wr && (k < n), k == n, k < n + g};
  endfunction
  task automatic txn(input string tag, input logic wr, input logic [1:0] a, input logic [2:0] d,
                     input bit poke, input logic [2:0] exp_rd);
    req = 1'b1; we = wr; adr = a; wdata = d;
    tick();
    req = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) begin
        if (poke && k == 5) begin req = 1'b1; adr = 2'b01; end
        tick();
        req = 1'b0;
      end
      check($sformatf("%s bus k=%0d", tag, k), 32'({bNE, bNOE, bNWE, bD_oe, done, busy}),
            32'(bus_exp(k, wr, 2, 8, 2, 2)));
      if (k < 12) check($sformatf("%s adr/data k=%0d", tag, k), 32'({bA, wr ? bD_out : 3'b000}),
                        32'({a, wr ? d : 3'b000}));
      if (k == 12) check({tag, " rdata"}, 32'(rdata), 32'(exp_rd));
    end
  endtask
  task automatic txn2(input string tag, input logic wr, input logic [1:0] a, input logic [2:0] d,
                      input logic [2:0] exp_rd);
    req2 = 1'b1; we2 = wr; adr2 = a; wdata2 = d;
    tick();
    req2 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) tick();
      check($sformatf("%s bus k=%0d", tag, k), 32'({bNE2, bNOE2, bNWE2, bD_oe2, done2, busy2}),
            32'(bus_exp(k, wr, 1, 1, 1, 1)));
      if (k == 3) check({tag, " rdata"}, 32'(rdata2), 32'(exp_rd));
    end
  endtask
  initial begin
    mem1 = '{default: 3'b000};
    mem2 = '{default: 3'b000};
    nrst = 1'b0; req = 1'b0; we = 1'b0; adr = 2'b00; wdata = 3'b000;
    req2 = 1'b0; we2 = 1'b0; adr2 = 2'b00; wdata2 = 3'b000;
    tick(); tick();
    check("reset bus", 32'({bNE, bNOE, bNWE, bD_oe, done, busy}), 32'(6'b111000));
    check("reset regs", 32'({bA, bD_out, rdata}), 32'(0));
    check("reset bus2", 32'({bNE2, bNOE2, bNWE2, bD_oe2, done2, busy2, bA2, bD_out2, rdata2}),
          32'({6'b111000, 8'h00}));
    nrst = 1'b1;
    tick(); tick();
    txn("wr", 1'b1, 2'b10, 3'b101, 1'b0, 3'b000);
    check("wr mem[2]", 32'(mem1[2]), 32'(3'b101));
    txn("rd", 1'b0, 2'b10, 3'b000, 1'b0, 3'b101);
    txn("rej", 1'b1, 2'b00, 3'b011, 1'b1, 3'b101);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rej idle %0d", i), 32'({bNE, busy, done}), 32'(3'b100));
    end
    check("rej mem[0]", 32'(mem1[0]), 32'(3'b011));
    check("rej mem[1]", 32'(mem1[1]), 32'(3'b000));
    req = 1'b1; we = 1'b1; adr = 2'b00; wdata = 3'b001;
    tick();
    adr = 2'b01; wdata = 3'b010;
    for (int k = 1; k <= 28; k++) begin
      tick();
      if (k == 14) req = 1'b0;
      check($sformatf("b2b bus k=%0d", k), 32'({bNE, bNOE, bNWE, bD_oe, done, busy}),
            32'(bus_exp(k >= 14 ? k - 14 : k, 1'b1, 2, 8, 2, 2)));
      check($sformatf("b2b adr k=%0d", k), 32'(bA), 32'(k < 14 ? 2'b00 : 2'b01));
    end
    check("b2b mem[0]", 32'(mem1[0]), 32'(3'b001));
    check("b2b mem[1]", 32'(mem1[1]), 32'(3'b010));
    req = 1'b1; we = 1'b1; adr = 2'b11; wdata = 3'b111;
    tick();
    req = 1'b0;
    repeat (5) tick();
    check("rst pre", 32'({bNE, bNWE, bD_oe, busy}), 32'(4'b0011));
    nrst = 1'b0;
    #1;
    check("rst async", 32'({bNE, bNOE, bNWE, bD_oe, busy, done, rdata}), 32'({6'b111000, 3'b000}));
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst hold %0d", i), 32'({bNE, done, busy}), 32'(3'b100));
    end
    nrst = 1'b1;
    tick();
    txn("after rst wr", 1'b1, 2'b11, 3'b110, 1'b0, 3'b000);
    txn("after rst rd", 1'b0, 2'b11, 3'b000, 1'b0, 3'b110);
    txn2("min wr", 1'b1, 2'b01, 3'b110, 3'b000);
    check("min mem[1]", 32'(mem2[1]), 32'(3'b110));
    txn2("min rd", 1'b0, 2'b01, 3'b000, 3'b110);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
